mux_stim_checker: RTL and testbench

MUX_STIM_CHECKER -- requirements
Module: mux_stim_checker

---
 rtl/mux_stim_checker.sv | 157 +++++++++++++++
 tb/tb_mux_stim_checker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mux_stim_checker.sv
// mux_stim_checker
//   Sweeps all eight {x,y,s} combinations into a downstream 2:1 mux. Each
//   vector is held for HOLD cycles and then sampled for one cycle. The mux
//   output returned on z_in is checked against s ? y : x, and mismatches are
//   counted.
//
//   Optional feature: define MUX_STIM_CHECK_EN to build the z_in comparison
//   and the err_cnt counting. Without it, z_in is ignored and err_cnt stays 0.
//   Sequencing and timing are the same in both builds.
//
// Parameters
//   HOLD    : cycles each vector is driven before its sample cycle (1..15)
//
// Ports
//   clk     : rising-edge clock
//   reset   : asynchronous, active-high reset
//   start   : begin a sweep (accepted only in IDLE, and only if abort is low)
//   abort   : abandon a sweep in progress and return to IDLE
//   z_in    : output of the mux under test
//   x, y, s : mux data input a, data input b and select (= vec[2], vec[1], vec[0])
//   vec     : current vector index
//   busy    : high while driving or sampling
//   done    : one-cycle pulse in the FINISH cycle
//   err_cnt : mismatches in the current or last sweep, saturating at 15
module mux_stim_checker #(
    parameter int HOLD = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       z_in,
    output logic       x,
    output logic       y,
    output logic       s,
    output logic [2:0] vec,
    output logic       busy,
    output logic       done,
    output logic [3:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    // The counter is loaded with HOLD-1 and counts down to 0.
    // This gives exactly HOLD cycles in DRIVE.
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

    state_t     state, state_d;
    logic [3:0] hold_cnt, hold_cnt_d;
    logic [2:0] vec_d;
    logic [3:0] err_d;
    logic       x_d, y_d, s_d, busy_d, done_d;
    logic       drv_d;
    logic       mismatch;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

`ifdef MUX_STIM_CHECK_EN
    // x/y/s are registered and still hold the vector during SAMPLE.
    // The reference value can therefore be taken straight from them.
    assign mismatch = (z_in != (s ? y : x));
`else
    logic unused_z_in;
    assign unused_z_in = z_in;
    assign mismatch    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= 4'd0;
            vec      <= 3'd0;
            err_cnt  <= 4'd0;
            x        <= 1'b0;
            y        <= 1'b0;
            s        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_cnt_d;
            vec      <= vec_d;
            err_cnt  <= err_d;
            x        <= x_d;
            y        <= y_d;
            s        <= s_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d    = state;
        hold_cnt_d = hold_cnt;
        vec_d      = vec;
        err_d      = err_cnt;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = DRIVE;
                    vec_d      = 3'd0;
                    err_d      = 4'd0;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hold_cnt == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    hold_cnt_d = hold_cnt - 4'd1;
                end
            end
            SAMPLE: begin
                // On abort, the sample in flight is discarded and err_cnt is frozen.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (mismatch) begin
                        err_d = sat_inc(err_cnt);
                    end
                    if (vec == 3'd7) begin
                        state_d = FINISH;
                    end else begin
                        state_d    = DRIVE;
                        vec_d      = vec + 3'd1;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so that they stay registered.
        drv_d  = (state_d == DRIVE) || (state_d == SAMPLE);
        x_d    = drv_d & vec_d[2];
        y_d    = drv_d & vec_d[1];
        s_d    = drv_d & vec_d[0];
        busy_d = drv_d;
        done_d = (state_d == FINISH);
    end

endmodule

// File: tb/tb_mux_stim_checker.sv
module tb_mux_stim_checker;

    localparam int HOLD = 2;
    localparam int VLEN = HOLD + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       z_in;
    logic       x, y, s;
    logic [2:0] vec;
    logic       busy;
    logic       done;
    logic [3:0] err_cnt;

    // z_in behaviour: 0 correct mux, 1 stuck at 0, 2 inverted, 3 random table
    logic [1:0] zmode = 2'd0;
    logic [7:0] rtbl  = 8'd0;

    int n_chk  = 0;
    int n_pass = 0;

    mux_stim_checker #(.HOLD(HOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .z_in    (z_in),
        .x       (x),
        .y       (y),
        .s       (s),
        .vec     (vec),
        .busy    (busy),
        .done    (done),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    // Downstream mux stand-in, optionally faulty.
    logic mux_true;
    assign mux_true = s ? y : x;
    assign z_in = (zmode == 2'd0) ? mux_true :
                  (zmode == 2'd1) ? 1'b0 :
                  (zmode == 2'd2) ? ~mux_true :
                                    rtbl[{x, y, s}];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: the ideal mux output for vector v, where {x,y,s} = v.
    function automatic int mux_ref(input int v);
        int xb, yb, sb;
        xb = (v >> 2) & 1;
        yb = (v >> 1) & 1;
        sb = v & 1;
        return (sb != 0) ? yb : xb;
    endfunction

    function automatic int z_ref(input int mode, input logic [7:0] tbl, input int v);
        case (mode)
            0:       return mux_ref(v);
            1:       return 0;
            2:       return 1 - mux_ref(v);
            default: return int'(tbl[v]);
        endcase
    endfunction

    // Expected error count after the first n vectors of a sweep have been sampled.
    function automatic int err_ref(input int mode, input logic [7:0] tbl, input int n);
        int c;
        c = 0;
`ifdef MUX_STIM_CHECK_EN
        for (int v = 0; v < n; v++)
            if (z_ref(mode, tbl, v) != mux_ref(v)) c++;
        if (c > 15) c = 15;
`endif
        return c;
    endfunction

    task automatic check_idle(input string nm, input int exp_vec, input int exp_err);
        check({nm, " busy"}, int'(busy), 0);
        check({nm, " done"}, int'(done), 0);
        check({nm, " xys"},  int'({x, y, s}), 0);
        check({nm, " vec"},  int'(vec), exp_vec);
        check({nm, " err"},  int'(err_cnt), exp_err);
    endtask

    // Called at a negedge with the DUT in IDLE. Ends at the negedge of the cycle after FINISH.
    task automatic sweep(input int mode, input logic [7:0] tbl, input string nm);
        int v, tot;
        zmode = 2'(mode);
        rtbl  = tbl;
        tot   = err_ref(mode, tbl, 8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 8 * VLEN + 2; k++) begin
            if (k <= 8 * VLEN) begin
                v = (k - 1) / VLEN;
                check($sformatf("%s k%0d vec", nm, k),  int'(vec), v);
                check($sformatf("%s k%0d xys", nm, k),  int'({x, y, s}), v);
                check($sformatf("%s k%0d busy", nm, k), int'(busy), 1);
                check($sformatf("%s k%0d done", nm, k), int'(done), 0);
                check($sformatf("%s k%0d err", nm, k),  int'(err_cnt), err_ref(mode, tbl, v));
            end else begin
                check($sformatf("%s k%0d vec", nm, k),  int'(vec), 7);
                check($sformatf("%s k%0d busy", nm, k), int'(busy), 0);
                check($sformatf("%s k%0d done", nm, k), int'(done), (k == 8 * VLEN + 1) ? 1 : 0);
                check($sformatf("%s k%0d err", nm, k),  int'(err_cnt), tot);
            end
            // Stray start requests while busy must be ignored.
            start = (k < 8 * VLEN) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (k < 8 * VLEN + 2) @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        #2;
        check_idle("reset", 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_reset", 0, 0);

        // Sweeps with a correct mux and a stuck-at-0 mux, then two back-to-back inverted sweeps.
        sweep(0, 8'h00, "good");
        sweep(1, 8'h00, "stuck0");
        sweep(2, 8'h00, "inv_a");
        sweep(2, 8'h00, "inv_b");

        // Abort in the first DRIVE cycle of vector 4.
        zmode = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4 * VLEN) @(negedge clk);
        check("abort pre vec",  int'(vec), 4);
        check("abort pre busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort", 4, err_ref(1, 8'h00, 4));
        for (int i = 0; i < 3 * VLEN; i++) begin
            @(negedge clk);
            check($sformatf("abort hold%0d done", i), int'(done), 0);
            check($sformatf("abort hold%0d vec", i),  int'(vec), 4);
        end

        // start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_idle("start_abort", 4, err_ref(1, 8'h00, 4));
        @(negedge clk);
        check_idle("start_abort2", 4, err_ref(1, 8'h00, 4));

        // Asynchronous reset during the SAMPLE cycle of vector 2.
        zmode = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * VLEN + HOLD) @(negedge clk);
        check("rst pre vec",  int'(vec), 2);
        check("rst pre busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check_idle("async_rst", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("rst_release", 0, 0);
        sweep(0, 8'h00, "after_rst");

        // Random fault patterns.
        for (int i = 0; i < 4; i++)
            sweep($urandom_range(0, 3), 8'($urandom), $sformatf("rnd%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
